// File: rtl/axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// axi_read_arbiter
//
// Shares one AXI4 read master port (AR + R channels) between two cache
// read-fill requesters: S0 (instruction cache) and S1 (data cache).
// One burst is in flight at a time. Arbitration is round-robin: on contention
// the requester that did not win last time is chosen, and a lone requester
// may win back-to-back. AW/W/B traffic is handled elsewhere.
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   S0_/S1_ARADDR/ARLEN/ARVALID  requester burst requests (held until ARREADY)
//   S0_/S1_ARREADY               combinational pulse when the master AR handshakes
//   S0_/S1_RDATA/RLAST/RVALID    read beats routed to the granted requester
//   M_AXI_ARADDR/ARLEN/ARVALID   registered master address channel
//   M_AXI_ARREADY                slave address accept
//   M_AXI_RDATA/RLAST/RVALID     slave read beats (always consumed, no RREADY)
//   ERR                          sticky protocol error (short/long burst, stray beat)
// -----------------------------------------------------------------------------
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] S0_ARADDR,
  input  logic [7:0]            S0_ARLEN,
  input  logic                  S0_ARVALID,
  output logic                  S0_ARREADY,
  output logic [DATA_WIDTH-1:0] S0_RDATA,
  output logic                  S0_RLAST,
  output logic                  S0_RVALID,
  input  logic [ADDR_WIDTH-1:0] S1_ARADDR,
  input  logic [7:0]            S1_ARLEN,
  input  logic                  S1_ARVALID,
  output logic                  S1_ARREADY,
  output logic [DATA_WIDTH-1:0] S1_RDATA,
  output logic                  S1_RLAST,
  output logic                  S1_RVALID,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  ERR
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]            state_r;
  logic                  grant_r;
  logic                  last_grant_r;
  logic [7:0]            beat_cnt_r;
  logic                  err_r;
  logic [ADDR_WIDTH-1:0] araddr_r;
  logic [7:0]            arlen_r;
  logic                  arvalid_r;

  logic                  any_req_s;
  logic                  win_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [7:0]            sel_len_s;
  logic                  in_data_s;

  assign any_req_s = S0_ARVALID | S1_ARVALID;
  assign in_data_s = (state_r == ST_DATA);

  // Round-robin winner selection and the winner's request fields.
  always_comb begin
    win_s      = 1'b0;
    sel_addr_s = {ADDR_WIDTH{1'b0}};
    sel_len_s  = 8'd0;
    if (S0_ARVALID && S1_ARVALID) begin
      win_s = ~last_grant_r;
    end else if (S1_ARVALID) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (win_s) begin
      sel_addr_s = S1_ARADDR;
      sel_len_s  = S1_ARLEN;
    end else begin
      sel_addr_s = S0_ARADDR;
      sel_len_s  = S0_ARLEN;
    end
  end

  // Arbitration FSM, master AR registers, beat counting and sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      beat_cnt_r   <= 8'd0;
      err_r        <= 1'b0;
      araddr_r     <= {ADDR_WIDTH{1'b0}};
      arlen_r      <= 8'd0;
      arvalid_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A beat with no burst outstanding is a protocol error.
          if (M_AXI_RVALID) begin
            err_r <= 1'b1;
          end
          if (any_req_s) begin
            grant_r   <= win_s;
            araddr_r  <= sel_addr_s;
            arlen_r   <= sel_len_s;
            arvalid_r <= 1'b1;
            state_r   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (M_AXI_RVALID) begin
            err_r <= 1'b1;
          end
          if (M_AXI_ARREADY) begin
            arvalid_r    <= 1'b0;
            last_grant_r <= grant_r;
            beat_cnt_r   <= 8'd0;
            state_r      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (M_AXI_RVALID) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
            if (M_AXI_RLAST) begin
              if (beat_cnt_r != arlen_r) begin
                err_r <= 1'b1;
              end
              // Arbitrate in the RLAST cycle so a waiting request reaches
              // the master one cycle after the last beat.
              if (any_req_s) begin
                grant_r   <= win_s;
                araddr_r  <= sel_addr_s;
                arlen_r   <= sel_len_s;
                arvalid_r <= 1'b1;
                state_r   <= ST_ADDR;
              end else begin
                state_r <= ST_IDLE;
              end
            end else if (beat_cnt_r == arlen_r) begin
              // Burst overran its length without RLAST; keep routing beats.
              err_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          arvalid_r <= 1'b0;
        end
      endcase
    end
  end

  assign M_AXI_ARADDR  = araddr_r;
  assign M_AXI_ARLEN   = arlen_r;
  assign M_AXI_ARVALID = arvalid_r;
  assign ERR           = err_r;

  assign S0_ARREADY = (state_r == ST_ADDR) && !grant_r && M_AXI_ARREADY;
  assign S1_ARREADY = (state_r == ST_ADDR) &&  grant_r && M_AXI_ARREADY;

  // Beats are only forwarded during a burst; stray beats reach nobody.
  assign S0_RVALID = in_data_s && !grant_r && M_AXI_RVALID;
  assign S1_RVALID = in_data_s &&  grant_r && M_AXI_RVALID;
  assign S0_RLAST  = in_data_s && !grant_r && M_AXI_RLAST;
  assign S1_RLAST  = in_data_s &&  grant_r && M_AXI_RLAST;
  assign S0_RDATA  = M_AXI_RDATA;
  assign S1_RDATA  = M_AXI_RDATA;

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] S0_ARADDR, S1_ARADDR, M_AXI_ARADDR;
  logic [7:0]  S0_ARLEN, S1_ARLEN, M_AXI_ARLEN;
  logic        S0_ARVALID, S1_ARVALID, S0_ARREADY, S1_ARREADY;
  logic [31:0] S0_RDATA, S1_RDATA, M_AXI_RDATA;
  logic        S0_RLAST, S1_RLAST, S0_RVALID, S1_RVALID;
  logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RLAST, M_AXI_RVALID, ERR;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARVALID(S0_ARVALID),
    .S0_ARREADY(S0_ARREADY), .S0_RDATA(S0_RDATA), .S0_RLAST(S0_RLAST), .S0_RVALID(S0_RVALID),
    .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARVALID(S1_ARVALID),
    .S1_ARREADY(S1_ARREADY), .S1_RDATA(S1_RDATA), .S1_RLAST(S1_RLAST), .S1_RVALID(S1_RVALID),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;      // reset before this round
    logic        v0, v1;   // which requesters ask
    logic [31:0] a0, a1;
    logic [7:0]  l0, l1;
    int          delay;    // cycles before slave ARREADY
    logic        win;      // hand-computed expected winner
    logic        exp_err;  // expected ERR after the burst
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    S0_ARVALID = 1'b0; S1_ARVALID = 1'b0;
    S0_ARADDR = 32'd0; S1_ARADDR = 32'd0; S0_ARLEN = 8'd0; S1_ARLEN = 8'd0;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RDATA = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Issue a request to IDLE, handshake AR after v.delay cycles, deliver len+1 beats.
  task automatic run_vec(input vec_t v, input int idx);
    int          n_win, n_lose, n_last, n_bad, beats;
    logic [31:0] exp_a;
    logic [7:0]  exp_l;
    logic        rv_w, rl_w, rv_l, rl_l;
    logic [31:0] rd_w;
    n_win = 0; n_lose = 0; n_last = 0; n_bad = 0;
    exp_a = v.win ? v.a1 : v.a0;
    exp_l = v.win ? v.l1 : v.l0;
    if (v.rst) do_reset();
    S0_ARVALID = v.v0; S0_ARADDR = v.a0; S0_ARLEN = v.l0;
    S1_ARVALID = v.v1; S1_ARADDR = v.a1; S1_ARLEN = v.l1;
    tick();
    check($sformatf("v%0d_arvalid_next", idx), M_AXI_ARVALID, 1'b1);
    check($sformatf("v%0d_araddr", idx), M_AXI_ARADDR, exp_a);
    check($sformatf("v%0d_arlen", idx), M_AXI_ARLEN, exp_l);
    for (int d = 0; d < v.delay; d++) begin
      tick();
      if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== exp_a || M_AXI_ARLEN !== exp_l ||
          S0_ARREADY !== 1'b0 || S1_ARREADY !== 1'b0) n_bad++;
    end
    check($sformatf("v%0d_ar_hold", idx), n_bad, 0);
    M_AXI_ARREADY = 1'b1;
    #1;
    check($sformatf("v%0d_s0_arready", idx), S0_ARREADY, !v.win);
    check($sformatf("v%0d_s1_arready", idx), S1_ARREADY, v.win);
    tick();
    M_AXI_ARREADY = 1'b0; S0_ARVALID = 1'b0; S1_ARVALID = 1'b0;
    check($sformatf("v%0d_arvalid_drop", idx), M_AXI_ARVALID, 1'b0);
    beats = int'(exp_l) + 1;
    n_bad = 0;
    for (int b = 0; b < beats; b++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RLAST  = (b == beats - 1);
      M_AXI_RDATA  = 32'hD000_0000 + 32'(b);
      #1;
      rv_w = v.win ? S1_RVALID : S0_RVALID;
      rl_w = v.win ? S1_RLAST  : S0_RLAST;
      rd_w = v.win ? S1_RDATA  : S0_RDATA;
      rv_l = v.win ? S0_RVALID : S1_RVALID;
      rl_l = v.win ? S0_RLAST  : S1_RLAST;
      if (rv_w === 1'b1) n_win++;
      if (rv_l !== 1'b0 || rl_l !== 1'b0) n_lose++;
      if (rl_w === 1'b1) begin
        n_last++;
        if (b != beats - 1) n_bad++;
      end
      if (rd_w !== 32'hD000_0000 + 32'(b)) n_bad++;
      tick();
    end
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    check($sformatf("v%0d_win_beats", idx), n_win, beats);
    check($sformatf("v%0d_lose_beats", idx), n_lose, 0);
    check($sformatf("v%0d_rlast_cnt", idx), n_last, 1);
    check($sformatf("v%0d_data_pos", idx), n_bad, 0);
    check($sformatf("v%0d_err", idx), ERR, v.exp_err);
    check($sformatf("v%0d_idle_arvalid", idx), M_AXI_ARVALID, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst v0 v1 a0 a1 l0 l1 delay win err
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h8000_1000, 32'h0, 8'h1f, 8'h00, 2, 1'b0, 1'b0}; // single S0
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 8'h03, 8'h03, 0, 1'b0, 1'b0}; // tie from reset: S0
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 8'h03, 8'h03, 1, 1'b1, 1'b0}; // then S1
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 8'h03, 8'h03, 0, 1'b0, 1'b0}; // S0 again
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_3000, 8'h00, 8'h07, 0, 1'b1, 1'b0};       // lone S1
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_3080, 8'h00, 8'h07, 3, 1'b1, 1'b0};       // lone S1 again
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_5000, 8'h00, 8'h01, 0, 1'b0, 1'b0}; // tie after S1: S0
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_5000, 8'h00, 8'h01, 0, 1'b1, 1'b0}; // tie after S0: S1

    RST = 1'b1;
    clear_inputs();
    do_reset();
    check("rst_arvalid", M_AXI_ARVALID, 1'b0);
    check("rst_araddr", M_AXI_ARADDR, 32'd0);
    check("rst_arlen", M_AXI_ARLEN, 8'd0);
    check("rst_err", ERR, 1'b0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // Back-to-back S1: second ARVALID one cycle after the first RLAST.
    do_reset();
    S1_ARVALID = 1'b1; S1_ARADDR = 32'h0000_3000; S1_ARLEN = 8'd1;
    tick();
    M_AXI_ARREADY = 1'b1;
    tick();
    M_AXI_ARREADY = 1'b0;
    S1_ARADDR = 32'h0000_3080; S1_ARLEN = 8'd0;   // next request already waiting
    M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b0;
    tick();
    M_AXI_RLAST = 1'b1;
    #1;
    check("b2b_rlast", S1_RLAST, 1'b1);
    check("b2b_arvalid_in_data", M_AXI_ARVALID, 1'b0);
    tick();
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    check("b2b_arvalid_next", M_AXI_ARVALID, 1'b1);
    check("b2b_araddr", M_AXI_ARADDR, 32'h0000_3080);
    M_AXI_ARREADY = 1'b1;
    #1;
    check("b2b_s1_arready", S1_ARREADY, 1'b1);
    tick();
    M_AXI_ARREADY = 1'b0; S1_ARVALID = 1'b0;
    M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1;
    #1;
    check("b2b_s1_rvalid", S1_RVALID, 1'b1);
    tick();
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    check("b2b_err", ERR, 1'b0);

    // Short RLAST: 16 beats of a 32-beat burst.
    do_reset();
    S0_ARVALID = 1'b1; S0_ARADDR = 32'h0000_4000; S0_ARLEN = 8'h1f;
    tick();
    M_AXI_ARREADY = 1'b1;
    tick();
    M_AXI_ARREADY = 1'b0; S0_ARVALID = 1'b0;
    for (int b = 0; b < 16; b++) begin
      M_AXI_RVALID = 1'b1; M_AXI_RLAST = (b == 15);
      tick();
    end
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    check("short_err", ERR, 1'b1);
    S0_ARVALID = 1'b1; S0_ARADDR = 32'h0000_5000; S0_ARLEN = 8'd0;
    tick();
    check("short_back_idle", M_AXI_ARVALID, 1'b1);
    check("short_new_addr", M_AXI_ARADDR, 32'h0000_5000);
    S0_ARVALID = 1'b0;
    tick(); tick(); tick();
    check("short_err_sticky", ERR, 1'b1);

    // Overrun: beat_cnt reaches ARLEN without RLAST, burst stays open.
    do_reset();
    S0_ARVALID = 1'b1; S0_ARADDR = 32'h0000_6000; S0_ARLEN = 8'd1;
    tick();
    M_AXI_ARREADY = 1'b1;
    tick();
    M_AXI_ARREADY = 1'b0; S0_ARVALID = 1'b0;
    M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b0;
    tick();
    check("over_err_early", ERR, 1'b0);
    tick();
    check("over_err", ERR, 1'b1);
    M_AXI_RLAST = 1'b1;
    #1;
    check("over_still_data", S0_RVALID, 1'b1);
    tick();
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    check("over_closed", M_AXI_ARVALID, 1'b0);

    // Stray beat while IDLE.
    do_reset();
    M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1;
    #1;
    check("stray_s0_rvalid", S0_RVALID, 1'b0);
    check("stray_s1_rvalid", S1_RVALID, 1'b0);
    check("stray_s0_rlast", S0_RLAST, 1'b0);
    tick();
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    check("stray_err", ERR, 1'b1);

    // Reset during beat 5, slave keeps sending one more beat afterwards.
    do_reset();
    S0_ARVALID = 1'b1; S0_ARADDR = 32'h0000_7000; S0_ARLEN = 8'd7;
    tick();
    M_AXI_ARREADY = 1'b1;
    tick();
    M_AXI_ARREADY = 1'b0; S0_ARVALID = 1'b0;
    M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b0;
    for (int b = 0; b < 4; b++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check("mid_rst_arvalid", M_AXI_ARVALID, 1'b0);
    check("mid_rst_s0_rvalid", S0_RVALID, 1'b0);
    check("mid_rst_err", ERR, 1'b0);
    tick();
    M_AXI_RVALID = 1'b0;
    check("mid_rst_stray_err", ERR, 1'b1);
    run_vec('{1'b0, 1'b1, 1'b0, 32'h0000_9000, 32'h0, 8'd2, 8'd0, 1, 1'b0, 1'b1}, 8);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
